// File: rtl/axil_ctrl_regs.sv
// rtl/axil_ctrl_regs.sv - AXI4-Lite control/status register file for global_controller
// Optional completion interrupt (GIE/IER/ISR and irq) is built when AXIL_IRQ_EN is defined.
`timescale 1ns/1ps
module axil_ctrl_regs #(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] K_DIM_RST = 32'd192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic              ap_start,
  output logic [31:0]       cfg_k_dim,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic [2:0]        state_dbg,
  output logic              irq
);
  localparam int          IW     = ADDR_W - 2;
  localparam logic [IW-1:0] A_CTRL = IW'(0);
  localparam logic [IW-1:0] A_KDIM = IW'(1);
  localparam logic [IW-1:0] A_CYC  = IW'(5);
  localparam logic [IW-1:0] A_ID   = IW'(6);
  localparam logic [31:0] ID_VAL = 32'hDE17_0001;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t      w_state, w_next;
  r_state_t      r_state, r_next;
  logic          wr_en, rd_en;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          ap_done_q, done_edge, done_r;
  logic          start_set, kdim_wr, kdim_busy;
  logic [31:0]   cycles, rd_val;
  logic          unused_addr_lsbs;

  assign wr_idx           = s_axil_awaddr[ADDR_W-1:2];
  assign rd_idx           = s_axil_araddr[ADDR_W-1:2];
  assign unused_addr_lsbs = &{1'b0, s_axil_awaddr[1:0], s_axil_araddr[1:0]};
  assign wr_en            = s_axil_awready;
  assign rd_en            = s_axil_arready;
  assign s_axil_rresp     = 2'b00;

  // Write channel: AW and W are only taken together, one outstanding response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next         = w_state;
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: if (s_axil_awvalid && s_axil_wvalid) begin
        s_axil_awready = 1'b1;
        s_axil_wready  = 1'b1;
        w_next         = W_RESP;
      end
      W_RESP: begin
        s_axil_bvalid = 1'b1;
        if (s_axil_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next         = r_state;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: if (s_axil_arvalid) begin
        s_axil_arready = 1'b1;
        r_next         = R_DATA;
      end
      R_DATA: begin
        s_axil_rvalid = 1'b1;
        if (s_axil_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign done_edge = ap_done && !ap_done_q;
  assign start_set = wr_en && (wr_idx == A_CTRL) && s_axil_wstrb[0] && s_axil_wdata[0]
                     && ap_idle && !ap_start;
  assign kdim_wr   = wr_en && (wr_idx == A_KDIM);
  assign kdim_busy = ap_start || !ap_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ap_done_q    <= 1'b0;
      ap_start     <= 1'b0;
      done_r       <= 1'b0;
      cfg_k_dim    <= K_DIM_RST;
      cycles       <= 32'd0;
      s_axil_bresp <= 2'b00;
    end else begin
      ap_done_q <= ap_done;
      if (start_set)      ap_start <= 1'b1;
      else if (done_edge) ap_start <= 1'b0;
      // A done edge coinciding with a CTRL read still leaves done set.
      if (done_edge)                             done_r <= 1'b1;
      else if (rd_en && (rd_idx == A_CTRL))      done_r <= 1'b0;
      if (kdim_wr && !kdim_busy) begin
        for (int b = 0; b < 4; b++)
          if (s_axil_wstrb[b]) cfg_k_dim[8*b +: 8] <= s_axil_wdata[8*b +: 8];
      end
      if (start_set)                              cycles <= 32'd0;
      else if (ap_start && (cycles != 32'hFFFF_FFFF)) cycles <= cycles + 32'd1;
      if (wr_en) s_axil_bresp <= (kdim_wr && kdim_busy) ? 2'b10 : 2'b00;
    end
  end

`ifdef AXIL_IRQ_EN
  localparam logic [IW-1:0] A_GIE = IW'(2);
  localparam logic [IW-1:0] A_IER = IW'(3);
  localparam logic [IW-1:0] A_ISR = IW'(4);
  logic gie, ier, isr, gie_nx, ier_nx, isr_nx;

  always_comb begin
    gie_nx = gie;
    ier_nx = ier;
    isr_nx = isr;
    if (wr_en && s_axil_wstrb[0]) begin
      if (wr_idx == A_GIE) gie_nx = s_axil_wdata[0];
      if (wr_idx == A_IER) ier_nx = s_axil_wdata[0];
      if ((wr_idx == A_ISR) && s_axil_wdata[0]) isr_nx = 1'b0;
    end
    if (done_edge) isr_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gie <= 1'b0;
      ier <= 1'b0;
      isr <= 1'b0;
      irq <= 1'b0;
    end else begin
      gie <= gie_nx;
      ier <= ier_nx;
      isr <= isr_nx;
      irq <= gie_nx && ier_nx && isr_nx;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_val = 32'd0;
    case (rd_idx)
      A_CTRL: rd_val = {25'd0, state_dbg, 1'b0, ap_idle, done_r, ap_start};
      A_KDIM: rd_val = cfg_k_dim;
`ifdef AXIL_IRQ_EN
      A_GIE:  rd_val = {31'd0, gie};
      A_IER:  rd_val = {31'd0, ier};
      A_ISR:  rd_val = {31'd0, isr};
`endif
      A_CYC:  rd_val = cycles;
      A_ID:   rd_val = ID_VAL;
      default: rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     s_axil_rdata <= 32'd0;
    else if (rd_en) s_axil_rdata <= rd_val;
  end
endmodule

// File: doc/axil_ctrl_regs.md
# axil_ctrl_regs

AXI4-Lite slave register file between the PS and `global_controller`. It turns CPU register writes into the controller's `ap_start` level and `cfg_k_dim` value. It reflects `ap_done`, `ap_idle` and the debug state back as readable status, measures run length in cycles, and, optionally, raises a completion interrupt.

## Interface
Parameters:
- `ADDR_W`, 6: AXI-Lite address width; byte addresses, 32-bit aligned, `addr[1:0]` ignored.
- `K_DIM_RST`, 192: reset value of `cfg_k_dim`.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axil_awaddr` in ADDR_W, `s_axil_awvalid` in 1, `s_axil_awready` out 1: write address channel.
- `s_axil_wdata` in 32, `s_axil_wstrb` in 4, `s_axil_wvalid` in 1, `s_axil_wready` out 1: write data channel.
- `s_axil_bresp` out 2, `s_axil_bvalid` out 1, `s_axil_bready` in 1: write response channel.
- `s_axil_araddr` in ADDR_W, `s_axil_arvalid` in 1, `s_axil_arready` out 1: read address channel.
- `s_axil_rdata` out 32, `s_axil_rresp` out 2, `s_axil_rvalid` out 1, `s_axil_rready` in 1: read data channel.
- `ap_start` out 1: start level to the controller.
- `cfg_k_dim` out 32: K dimension to the controller.
- `ap_done` in 1, `ap_idle` in 1, `state_dbg` in 3: status from the controller.
- `irq` out 1: completion interrupt, level-high.

## Operation
Register map:
- 0x00 CTRL:
  - bit0 `ap_start`, RW1S.
  - bit1 `done`, RO, sticky, clear-on-read.
  - bit2 `ap_idle`, RO, live.
  - bits[6:4] `state_dbg`, RO, live.
- 0x04 K_DIM: RW, 32 bits, byte-strobed.
- 0x08 GIE: bit0 global interrupt enable. Present only with the macro.
- 0x0C IER: bit0 done interrupt enable. Present only with the macro.
- 0x10 ISR: bit0 done status, W1C. Present only with the macro.
- 0x14 CYCLES: RO cycle count of the current or last run.
- 0x18 ID: RO constant 0xDE17_0001.
- Unmapped: reads return 0 with OKAY; writes are ignored with OKAY.

Start and done behaviour:
- Start: a write of 1 to CTRL bit0 (with `wstrb[0]`=1) sets `ap_start` only if `ap_idle`=1 and `ap_start`=0. Otherwise the write is ignored. Writing 0 never clears `ap_start`; there is no abort.
- Done edge: this is the rising edge of `ap_done`, detected with one registered copy of `ap_done`.
  - It clears `ap_start`.
  - It sets `done` and ISR bit0.
  - Repeated high cycles of `ap_done` count as one event.
- K_DIM write while busy (`ap_start`=1 or `ap_idle`=0): value is unchanged and the response is SLVERR (2'b10). All other responses are OKAY.
- CYCLES:
  - Clears to 0 on the cycle `ap_start` sets.
  - Increments each cycle while `ap_start`=1.
  - Saturates at 0xFFFF_FFFF.
  - Holds its value after the done edge.

Write FSM (W_IDLE, W_RESP):
- In W_IDLE, when `awvalid`&&`wvalid`, assert `awready` and `wready` together for one cycle, apply the write on that edge, then go to W_RESP.
- In W_RESP, `bvalid`=1 until `bready`, then return to W_IDLE.
- AW or W alone is never accepted.

Read FSM (R_IDLE, R_DATA):
- In R_IDLE, when `arvalid`, pulse `arready` and capture `rdata` on that edge, then go to R_DATA.
- In R_DATA, `rvalid`=1 and `rdata` is stable until `rready`.
- Clear-on-read of `done` happens at `arready`.

## Timing
- Reset values:
  - `ap_start`=0, `cfg_k_dim`=K_DIM_RST, `irq`=0.
  - All ready and valid outputs are 0; `bresp`=`rresp`=0; `rdata`=0.
  - `done`=0, CYCLES=0, GIE=IER=ISR=0.
- Reset mid-transaction drops any pending response. The next transaction starts clean.
- `ap_start` and `cfg_k_dim` change on the edge where `awready`&&`wready` are high. The first `bvalid` cycle already shows the new value.
- Done edge to `ap_start`=0 and `done`=1: one cycle after `ap_done` first samples high.
- Read latency: `rvalid` is high the cycle after `arready`. Minimum read cycle is 2 clocks; minimum write cycle is 2 clocks.
- Simultaneous events:
  - If a read of CTRL and a done edge fall on the same cycle, the read returns `done`=0 and `done` ends up 1. Set wins.
  - If an ISR W1C and a done edge fall on the same cycle, ISR bit0 ends up 1.
  - If a start write and a done edge fall on the same cycle, the start is ignored, because `ap_start` is still 1.
- Read and write channels operate concurrently and independently.

## Configuration
- `AXIL_IRQ_EN` defined:
  - GIE, IER and ISR exist.
  - `irq` is registered: `irq` = GIE[0] & IER[0] & ISR[0], updated one cycle after any input change.
- `AXIL_IRQ_EN` undefined:
  - GIE, IER and ISR are not implemented and behave as unmapped (read 0, writes ignored).
  - `irq` is tied to 0.

## Test plan
- Reset, then read 0x04, 0x18 and 0x00 with `ap_idle`=1. Expect 192 OKAY, 0xDE17_0001, and 0x0000_0004.
- Write 0x04=0x40 and 0x00=1. Expect `ap_start`=1 and `cfg_k_dim`=64. Hold `ap_done` high for 2 cycles after 80 cycles. Expect:
  - `ap_start` falls once.
  - CYCLES=81±1.
  - CTRL reads bit1=1, and a second read returns bit1=0.
- While `ap_start`=1, write 0x04=0x10. Expect BRESP=SLVERR and `cfg_k_dim` unchanged at 64. Also write 0x00=0 and expect `ap_start` still 1.
- Byte strobe: write 0x04 with data 0xAABBCCDD and `wstrb`=4'b0010 from 192. Expect 0x0000_CCC0.
- Backpressure: present AW and W, then hold `bready`=0 for 5 cycles. Expect `bvalid` held, no further AW/W accepted, and a concurrent read completes normally.
- With the macro, set GIE=IER=1 and complete a run. Expect `irq`=1. Write ISR=1 and expect `irq`=0 the cycle after. Without the macro, expect `irq`=0 and 0x08 reading 0.
